// File: rtl/piece_pkg.sv
// Shared definitions for the piece compositor: default sizes, the reset
// palette table and the scatter sequencer state encoding.
package piece_pkg;

    localparam int N_SHAPES_DEF    = 7;
    localparam int COLOR_W_DEF     = 4;
    localparam int SCATTER_GAP_DEF = 10;
    localparam int PAL_DEPTH_MAX   = 16;

    // Reset palette as 1-bit-per-channel {R,G,B} codes: entry i holds code
    // (i+1) modulo 8, so entry 0 is blue, entry 3 is red, entry 6 is white.
    localparam logic [PAL_DEPTH_MAX-1:0][2:0] DEFAULT_PAL_CODE = {
        3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1,
        3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1
    };

    typedef enum logic [1:0] {
        SC_IDLE  = 2'd0,
        SC_PULSE = 2'd1,
        SC_GAP   = 2'd2,
        SC_DONE  = 2'd3
    } scatter_state_t;

endpackage

// File: rtl/piece_compositor_scatter_seq.sv
// Scatter sequencer: on a rising edge of the scatter request it emits one
// single-cycle flag per shape, in index order, spaced SCATTER_GAP+1 cycles
// apart. A request that is still high afterwards must drop before the
// sequence can be started again.
module scatter_seq
    import piece_pkg::*;
#(
    parameter int N_SHAPES    = N_SHAPES_DEF,
    parameter int SCATTER_GAP = SCATTER_GAP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                scatter_req,
    output logic [N_SHAPES-1:0] scatter_flag,
    output logic                scatter_busy
);

    localparam int IDX_W = $clog2(N_SHAPES);
    localparam int GAP_W = (SCATTER_GAP > 1) ? $clog2(SCATTER_GAP) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_SHAPES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCATTER_GAP - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    scatter_state_t   state_reg;
    logic [IDX_W-1:0] index_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             req_prev_reg;
    logic             req_rise;

    assign req_rise = scatter_req & ~req_prev_reg;

    function automatic logic [N_SHAPES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return N_SHAPES'(1) << idx;
    endfunction

    // Sequencer state, counters and registered flag/busy outputs.
    // req_prev resets high so a request already held during reset is not
    // mistaken for a fresh rising edge once reset is released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= SC_IDLE;
            index_reg    <= '0;
            gap_cnt_reg  <= '0;
            req_prev_reg <= 1'b1;
            scatter_flag <= '0;
            scatter_busy <= 1'b0;
        end else begin
            req_prev_reg <= scatter_req;
            scatter_flag <= '0;
            case (state_reg)
                SC_IDLE: begin
                    scatter_busy <= 1'b0;
                    if (req_rise) begin
                        state_reg    <= SC_PULSE;
                        index_reg    <= '0;
                        gap_cnt_reg  <= '0;
                        scatter_flag <= onehot('0);
                        scatter_busy <= 1'b1;
                    end
                end
                SC_PULSE: begin
                    gap_cnt_reg <= '0;
                    if (index_reg == IDX_LAST) begin
                        state_reg    <= SC_DONE;
                        scatter_busy <= 1'b0;
                    end else begin
                        state_reg <= SC_GAP;
                    end
                end
                SC_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        gap_cnt_reg  <= '0;
                        index_reg    <= index_reg + IDX_ONE;
                        state_reg    <= SC_PULSE;
                        scatter_flag <= onehot(index_reg + IDX_ONE);
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_ONE;
                    end
                end
                SC_DONE: begin
                    scatter_busy <= 1'b0;
                    if (!scatter_req) begin
                        state_reg <= SC_IDLE;
                    end
                end
                default: begin
                    state_reg    <= SC_IDLE;
                    scatter_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/piece_compositor.sv
// Piece compositor: picks the winning shape for each pixel, looks its colour
// up in a writable palette and delays the syncs to match (2-cycle latency).
// Also hosts the scatter sequencer.
// Optional feature macro: OVERLAP_FLASH_EN -- when defined, pixels covered by
// two or more shapes flash all-ones for 16 frames out of every 32.
module piece_compositor
    import piece_pkg::*;
#(
    parameter int N_SHAPES    = N_SHAPES_DEF,
    parameter int COLOR_W     = COLOR_W_DEF,
    parameter int SCATTER_GAP = SCATTER_GAP_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_SHAPES-1:0]    hit,
    input  logic                   vidon,
    input  logic                   hsync_in,
    input  logic                   vsync_in,
    input  logic [N_SHAPES-1:0]    select,
    input  logic                   scatter_req,
    input  logic                   pal_we,
    input  logic [3:0]             pal_addr,
    input  logic [3*COLOR_W-1:0]   pal_data,
    output logic [N_SHAPES-1:0]    scatter_flag,
    output logic                   scatter_busy,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     green,
    output logic [COLOR_W-1:0]     blue,
    output logic                   hsync_out,
    output logic                   vsync_out
);

    localparam int IDX_W = $clog2(N_SHAPES);
    localparam int PIX_W = 3 * COLOR_W;

    // ---------------------------------------------------------------
    // Palette
    // ---------------------------------------------------------------
    logic [N_SHAPES-1:0][PIX_W-1:0] palette_reg;
    logic [N_SHAPES-1:0][PIX_W-1:0] pal_default;

    genvar gi;
    for (gi = 0; gi < N_SHAPES; gi++) begin : g_pal_default
        localparam logic [2:0] CODE = DEFAULT_PAL_CODE[gi];
        assign pal_default[gi] = {{COLOR_W{CODE[2]}}, {COLOR_W{CODE[1]}}, {COLOR_W{CODE[0]}}};
    end

    // Palette storage; writes to addresses beyond the last shape match no entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            palette_reg <= pal_default;
        end else begin
            for (int i = 0; i < N_SHAPES; i++) begin
                if (pal_we && (pal_addr == 4'(i))) begin
                    palette_reg[i] <= pal_data;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Winner selection (combinational, feeds stage 1)
    // ---------------------------------------------------------------
    logic [N_SHAPES-1:0] sel_hit;
    logic [IDX_W-1:0]    sel_idx;
    logic [IDX_W-1:0]    any_idx;
    logic [IDX_W-1:0]    win_idx;
    logic                sel_found;
    logic                any_found;

    // Lowest selected-and-hit shape wins; otherwise the lowest hit shape.
    always_comb begin
        sel_hit   = hit & select;
        sel_idx   = '0;
        any_idx   = '0;
        sel_found = 1'b0;
        any_found = 1'b0;
        for (int i = N_SHAPES - 1; i >= 0; i--) begin
            if (sel_hit[i]) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
            if (hit[i]) begin
                any_idx   = IDX_W'(i);
                any_found = 1'b1;
            end
        end
        win_idx = sel_found ? sel_idx : any_idx;
    end

    // ---------------------------------------------------------------
    // Stage 1
    // ---------------------------------------------------------------
    logic [IDX_W-1:0] s1_idx_reg;
    logic             s1_hit_reg;
    logic             s1_vid_reg;
    logic             s1_hsync_reg;
    logic             s1_vsync_reg;

    // Register winner, coverage, video qualifier and syncs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_idx_reg   <= '0;
            s1_hit_reg   <= 1'b0;
            s1_vid_reg   <= 1'b0;
            s1_hsync_reg <= 1'b1;
            s1_vsync_reg <= 1'b1;
        end else begin
            s1_idx_reg   <= win_idx;
            s1_hit_reg   <= any_found;
            s1_vid_reg   <= vidon;
            s1_hsync_reg <= hsync_in;
            s1_vsync_reg <= vsync_in;
        end
    end

`ifdef OVERLAP_FLASH_EN
    localparam logic [N_SHAPES-1:0] HIT_ONE = N_SHAPES'(1);

    logic       overlap;
    logic       s1_overlap_reg;
    logic       vsync_prev_reg;
    logic [4:0] frame_cnt_reg;

    // Two or more bits set: clearing the lowest set bit leaves something.
    assign overlap = |(hit & (hit - HIT_ONE));

    // Overlap flag travels with its pixel through stage 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_overlap_reg <= 1'b0;
        end else begin
            s1_overlap_reg <= overlap;
        end
    end

    // Count vsync falling edges; bit 4 toggles every 16 frames.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_prev_reg <= 1'b1;
            frame_cnt_reg  <= '0;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (vsync_prev_reg && !vsync_in) begin
                frame_cnt_reg <= frame_cnt_reg + 5'd1;
            end
        end
    end
`endif

    // ---------------------------------------------------------------
    // Stage 2
    // ---------------------------------------------------------------
    logic [PIX_W-1:0] pix_reg;

    // Palette lookup (or blanking / overlap flash) and sync alignment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_reg   <= '0;
            hsync_out <= 1'b1;
            vsync_out <= 1'b1;
        end else begin
            hsync_out <= s1_hsync_reg;
            vsync_out <= s1_vsync_reg;
            if (!s1_vid_reg || !s1_hit_reg) begin
                pix_reg <= '0;
`ifdef OVERLAP_FLASH_EN
            end else if (s1_overlap_reg && frame_cnt_reg[4]) begin
                pix_reg <= '1;
`endif
            end else begin
                pix_reg <= palette_reg[s1_idx_reg];
            end
        end
    end

    assign red   = pix_reg[PIX_W-1 -: COLOR_W];
    assign green = pix_reg[2*COLOR_W-1 -: COLOR_W];
    assign blue  = pix_reg[COLOR_W-1:0];

    // ---------------------------------------------------------------
    // Scatter sequencer
    // ---------------------------------------------------------------
    scatter_seq #(
        .N_SHAPES    (N_SHAPES),
        .SCATTER_GAP (SCATTER_GAP)
    ) u_scatter_seq (
        .clk          (clk),
        .reset        (reset),
        .scatter_req  (scatter_req),
        .scatter_flag (scatter_flag),
        .scatter_busy (scatter_busy)
    );

endmodule

// File: tb/tb_piece_compositor.sv
// Directed testbench for piece_compositor with default parameters
// (7 shapes, 4-bit colour, scatter gap 10).
module tb_piece_compositor;

    localparam int N  = 7;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    hit;
    logic            vidon;
    logic            hsync_in;
    logic            vsync_in;
    logic [N-1:0]    select;
    logic            scatter_req;
    logic            pal_we;
    logic [3:0]      pal_addr;
    logic [3*CW-1:0] pal_data;
    logic [N-1:0]    scatter_flag;
    logic            scatter_busy;
    logic [CW-1:0]   red;
    logic [CW-1:0]   green;
    logic [CW-1:0]   blue;
    logic            hsync_out;
    logic            vsync_out;

    logic [3*CW-1:0] rgb;
    assign rgb = {red, green, blue};

    int tests_run    = 0;
    int tests_failed = 0;

    piece_compositor dut (
        .clk          (clk),
        .reset        (reset),
        .hit          (hit),
        .vidon        (vidon),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .select       (select),
        .scatter_req  (scatter_req),
        .pal_we       (pal_we),
        .pal_addr     (pal_addr),
        .pal_data     (pal_data),
        .scatter_flag (scatter_flag),
        .scatter_busy (scatter_busy),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Let a pixel presented at the current negedge reach the outputs.
    task automatic pix_wait();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    // One-cycle palette write issued from a negedge.
    task automatic pal_write(input logic [3:0] addr, input logic [3*CW-1:0] data);
        pal_we   = 1'b1;
        pal_addr = addr;
        pal_data = data;
        @(posedge clk);
        @(negedge clk);
        pal_we   = 1'b0;
    endtask

    initial begin
        logic [N-1:0] flag_exp;
        logic         busy_exp;
        logic [3*CW-1:0] ovl_exp;

        reset = 1'b1; hit = '0; vidon = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        select = '0; scatter_req = 1'b0; pal_we = 1'b0; pal_addr = '0; pal_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rgb",   rgb,          0);
        check("reset_hsync", hsync_out,    1);
        check("reset_vsync", vsync_out,    1);
        check("reset_flag",  scatter_flag, 0);
        check("reset_busy",  scatter_busy, 0);
        reset = 1'b0;

        // Winner selection against the default palette.
        hit = 7'b0000110; select = '0; vidon = 1'b1;
        pix_wait(); check("win_lowest_hit", rgb, 12'h0F0);
        select = 7'b0000100;
        pix_wait(); check("win_selected", rgb, 12'h0FF);
        select = 7'b0001000;
        pix_wait(); check("win_sel_not_hit", rgb, 12'h0F0);
        vidon = 1'b0;
        pix_wait(); check("vidon_low", rgb, 12'h000);
        vidon = 1'b1; hit = '0; select = '0;
        pix_wait(); check("no_hit", rgb, 12'h000);
        hit = 7'b0000001;
        pix_wait(); check("pal0_default", rgb, 12'h00F);
        hit = 7'b1000000;
        pix_wait(); check("pal6_default", rgb, 12'hFFF);
        hit = 7'b0100000;
        pix_wait(); check("pal5_default", rgb, 12'hFF0);

        // Two-cycle latency of colour and sync.
        hit = 7'b0010000; hsync_in = 1'b0;
        @(posedge clk); @(negedge clk);
        check("lat1_rgb",   rgb,       12'hFF0);
        check("lat1_hsync", hsync_out, 1);
        @(posedge clk); @(negedge clk);
        check("lat2_rgb",   rgb,       12'hF0F);
        check("lat2_hsync", hsync_out, 0);
        hsync_in = 1'b1;

        // Palette write timing: the pixel already in stage 1 sees the old entry.
        pal_write(4'd4, 12'h5A3);
        check("pal_write_not_early", rgb, 12'hF0F);
        @(posedge clk); @(negedge clk);
        check("pal_write_next", rgb, 12'h5A3);

        // Palette writes to entry 3 and an out-of-range address.
        hit = 7'b0001000;
        pal_write(4'd3, 12'h123);
        pix_wait(); check("pal3_write_123", rgb, 12'h123);
        pal_write(4'd3, 12'hF00);
        pix_wait(); check("pal3_write_red", rgb, 12'hF00);
        pal_write(4'd9, 12'hABC);
        pix_wait(); check("pal_addr9_ignored_3", rgb, 12'hF00);
        hit = 7'b0000010;
        pix_wait(); check("pal_addr9_ignored_1", rgb, 12'h0F0);

        // Overlap across 32 frames.
        hit = 7'b0000011;
        pix_wait(); check("overlap_frame0", rgb, 12'h00F);
`ifdef OVERLAP_FLASH_EN
        ovl_exp = 12'hFFF;
`else
        ovl_exp = 12'h00F;
`endif
        for (int f = 0; f < 16; f++) begin
            vsync_in = 1'b0; @(negedge clk);
            vsync_in = 1'b1; @(negedge clk);
        end
        pix_wait(); check("overlap_frame16", rgb, ovl_exp);
        for (int f = 0; f < 16; f++) begin
            vsync_in = 1'b0; @(negedge clk);
            vsync_in = 1'b1; @(negedge clk);
        end
        pix_wait(); check("overlap_frame32", rgb, 12'h00F);

        // Scatter: pulses at cycles 1,12,...,67; a re-edge at cycle 32 is ignored.
        scatter_req = 1'b1;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); @(negedge clk);
            flag_exp = '0;
            if (k <= 67 && ((k - 1) % 11) == 0) flag_exp[(k - 1) / 11] = 1'b1;
            busy_exp = (k <= 67);
            check($sformatf("scatter_c%0d", k), {busy_exp ? 1'b0 : 1'b0, scatter_busy, scatter_flag},
                  {1'b0, busy_exp, flag_exp});
            if (k == 30) scatter_req = 1'b0;
            if (k == 31) scatter_req = 1'b1;
        end

        // Drop and raise again: the sequence restarts.
        scatter_req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("scatter_idle_flag", scatter_flag, 0);
        scatter_req = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(posedge clk); @(negedge clk);
            flag_exp = '0;
            if (((k - 1) % 11) == 0) flag_exp[(k - 1) / 11] = 1'b1;
            check($sformatf("rescatter_c%0d", k), {scatter_busy, scatter_flag}, {1'b1, flag_exp});
        end

        // Reset right after the third pulse.
        check("pre_reset_rgb", rgb, 12'h00F);
        reset = 1'b1;
        #1;
        check("mid_reset_flag",  scatter_flag, 0);
        check("mid_reset_busy",  scatter_busy, 0);
        check("mid_reset_rgb",   rgb,          0);
        check("mid_reset_hsync", hsync_out,    1);
        @(posedge clk); @(posedge clk); @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("post_reset_c%0d", k), {scatter_busy, scatter_flag}, 0);
        end

        // Palette is back to its default table.
        hit = 7'b0010000;
        pix_wait(); check("pal4_after_reset", rgb, 12'hF0F);

        // A fresh request works after reset.
        scatter_req = 1'b0;
        @(posedge clk); @(negedge clk);
        scatter_req = 1'b1;
        @(posedge clk); @(negedge clk);
        check("scatter_after_reset", {scatter_busy, scatter_flag}, {1'b1, 7'b0000001});

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/piece_compositor.md
PIECE_COMPOSITOR -- requirements
Module: piece_compositor

Interface
REQ-001 Parameter N_SHAPES, default 7, number of shape channels (2..16).
REQ-002 Parameter COLOR_W, default 4, bits per RGB component.
REQ-003 Parameter SCATTER_GAP, default 10, clock cycles between consecutive scatter pulses (>=1).
REQ-004 clk  in  1  pixel clock; single clock domain.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 hit  in  N_SHAPES  per-shape coverage of current pixel, bit i = shape i covers pixel.
REQ-007 vidon  in  1  active-video qualifier for current pixel.
REQ-008 hsync_in, vsync_in  in  1 each  raw sync from VGA timing generator.
REQ-009 select  in  N_SHAPES  shapes currently selected by the user.
REQ-010 scatter_req  in  1  debounced level request to scatter all shapes.
REQ-011 pal_we, pal_addr, pal_data  in  1 / 4 / 3*COLOR_W  palette write port, {R,G,B} order.
REQ-012 scatter_flag  out  N_SHAPES  one-hot, one-cycle pulse per shape during scatter.
REQ-013 scatter_busy  out  1  high while scatter sequence runs.
REQ-014 red, green, blue  out  COLOR_W each  registered pixel colour.
REQ-015 hsync_out, vsync_out  out  1 each  sync delayed to align with colour.

Function
REQ-016 Pixel path SHALL be a 2-stage pipeline: stage 1 registers winning index, any-hit, overlap flag, vidon, syncs; stage 2 registers palette lookup; latency exactly 2 cycles for colour and sync.
REQ-017 Winner SHALL be lowest-index hit among selected shapes; if none selected-and-hit, lowest-index hit overall.
REQ-018 No hit or vidon low at stage 1 SHALL produce red=green=blue=0 at output.
REQ-019 Palette SHALL hold N_SHAPES entries; pal_we with pal_addr>=N_SHAPES SHALL be ignored; write takes effect for pixels entering stage 2 on the following cycle.
REQ-020 Scatter FSM states: IDLE, PULSE, GAP, DONE.
REQ-021 IDLE->PULSE on scatter_req rising edge (0 then 1 on consecutive cycles); index=0.
REQ-022 PULSE asserts scatter_flag[index] for one cycle; ->GAP if index<N_SHAPES-1, else ->DONE.
REQ-023 GAP counts SCATTER_GAP cycles, then index+1, ->PULSE; pulse-to-pulse spacing = SCATTER_GAP+1 cycles.
REQ-024 DONE->IDLE when scatter_req low; a held-high request SHALL NOT retrigger.
REQ-025 scatter_busy high in PULSE and GAP only; further rising edges while busy are ignored.
REQ-026 scatter_flag SHALL be zero outside PULSE; never more than one bit set.

Reset
REQ-027 Reset SHALL force FSM to IDLE, index and gap counter to 0, scatter_flag=0, scatter_busy=0, colour outputs 0, hsync_out=vsync_out=1, pipeline valid bits 0.
REQ-028 Palette SHALL reset to package default table (entry i = colour code i+1 on 1-bit-per-channel RGB, expanded to COLOR_W).
REQ-029 Reset mid-scatter SHALL abort without emitting any further pulse.

Configuration
REQ-030 OVERLAP_FLASH_EN defined: pixels hit by >=2 shapes SHALL show all-ones colour while a frame counter bit (toggling every 16 vsync_in falling edges) is 1, else winner colour; counter resets to 0.
REQ-031 OVERLAP_FLASH_EN undefined: overlap pixels SHALL show winner colour; frame counter absent.

Structure
REQ-032 Package piece_pkg SHALL hold COLOR_W default, N_SHAPES default, default palette table, scatter state enum.
REQ-033 Scatter FSM SHALL be sub-module scatter_seq; priority/palette pipeline stays in piece_compositor.

Verification
REQ-034 hit=7'b0000110, select=0, vidon=1 -> two cycles later colour = palette[1].
REQ-035 hit=7'b0000110, select=7'b0000100 -> colour = palette[2]; vidon=0 -> colour 0.
REQ-036 scatter_req 0->1 held, SCATTER_GAP=10 -> flags bits 0..6 at cycles 1,12,23,...,67, busy then low, no retrigger until req drops and rises.
REQ-037 reset asserted after third pulse -> no further flags, busy=0, outputs 0 immediately.
REQ-038 pal_we addr 3 data 0xF00 then hit bit 3 -> colour red=0xF,green=0,blue=0; addr 9 write -> palette unchanged.
REQ-039 OVERLAP_FLASH_EN, hit=7'b0000011 across 32 frames -> alternating 16 frames winner, 16 frames 0xFFF.
